// File: rtl/floo_serial_link_channel_arb.sv
// floo_serial_link_channel_arb: weighted round-robin, credit-gated arbiter of three flit classes onto one serial link (optional FLOO_SL_ARB_PERF_CNT_EN grant counters)
module floo_serial_link_channel_arb #(
  parameter int unsigned FlitWidth   = 128,
  parameter int unsigned NumCredits  = 8,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned CntWidth    = $clog2(NumCredits + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [2:0][FlitWidth-1:0]           in_data_i,
  input  logic [2:0]                          in_valid_i,
  output logic [2:0]                          in_ready_o,
  output logic [FlitWidth-1:0]                out_data_o,
  output logic [1:0]                          out_cls_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  input  logic [2:0]                          credit_ret_i,
  input  logic [2:0][WeightWidth-1:0]         weight_i,
  output logic [2:0][CntWidth-1:0]            credit_cnt_o,
  output logic                                credit_err_o
`ifdef FLOO_SL_ARB_PERF_CNT_EN
  ,
  output logic [2:0][31:0]                    perf_grant_cnt_o
`endif
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [CntWidth-1:0] Full = CntWidth'(NumCredits);
  logic [0:0] state;
  logic [1:0] ptr, cur, base, b1, b2, pick, sel;
  logic [WeightWidth-1:0] burst, wmax;
  logic [2:0] elig;
  logic slot, cont, any, grant;
  function automatic logic [1:0] nxt(input logic [1:0] c);
    return c == 2'd2 ? 2'd0 : c + 2'd1;
  endfunction
  always_comb begin
    elig = '0;
    for (int c = 0; c < 3; c++) elig[c] = in_valid_i[c] && credit_cnt_o[c] != '0;
  end
  assign slot = enable_i && (!out_valid_o || out_ready_i);
  assign wmax = weight_i[cur] == '0 ? WeightWidth'(1) : weight_i[cur];
  assign cont = state == S_BURST && elig[cur] && burst < wmax;
  // a finished burst searches from the class after it, same cycle
  assign base = state == S_BURST ? nxt(cur) : ptr;
  assign b1 = nxt(base);
  assign b2 = nxt(b1);
  assign pick = elig[base] ? base : elig[b1] ? b1 : b2;
  assign any = |elig;
  assign sel = cont ? cur : pick;
  assign grant = slot && (cont || any);
  assign in_ready_o = grant ? 3'(3'b001 << sel) : 3'b000;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      out_cls_o <= '0;
      credit_err_o <= 1'b0;
      ptr <= '0;
      cur <= '0;
      burst <= '0;
      state <= S_IDLE;
      for (int c = 0; c < 3; c++) credit_cnt_o[c] <= Full;
    end else begin
      if (grant) begin
        out_valid_o <= 1'b1;
        out_data_o <= in_data_i[sel];
        out_cls_o <= sel;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (slot) begin
        if (cont) begin
          burst <= burst + WeightWidth'(1);
        end else begin
          if (state == S_BURST) ptr <= nxt(cur);
          if (any) begin
            state <= S_BURST;
            cur <= pick;
            burst <= WeightWidth'(1);
          end else begin
            state <= S_IDLE;
          end
        end
      end
      for (int c = 0; c < 3; c++) begin
        if (credit_ret_i[c] && !(grant && sel == 2'(c))) begin
          if (credit_cnt_o[c] == Full) credit_err_o <= 1'b1;
          else credit_cnt_o[c] <= credit_cnt_o[c] + CntWidth'(1);
        end else if (!credit_ret_i[c] && grant && sel == 2'(c)) begin
          credit_cnt_o[c] <= credit_cnt_o[c] - CntWidth'(1);
        end
      end
    end
  end
`ifdef FLOO_SL_ARB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_grant_cnt_o <= '0;
    else if (grant) perf_grant_cnt_o[sel] <= perf_grant_cnt_o[sel] + 32'd1;
  end
`endif
endmodule
